// File: rtl/pool_apb_master.sv
// Pool accelerator job sequencer. For each accepted command it programs the
// feature length and input-channel count over APB, sets start, polls done,
// reads the clock counter, clears start, and then reports cycles and error.
module pool_apb_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [7:0]  CTRL_OFS  = 8'h00,
    parameter logic [7:0]  FLEN_OFS  = 8'h04,
    parameter logic [7:0]  INCH_OFS  = 8'h08,
    parameter logic [7:0]  CNT_OFS   = 8'h0C,
    parameter logic [15:0] POLL_MAX  = 16'hFFFF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_flen,
    input  logic [8:0]  cmd_inch,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_cycles,
    output logic        rsp_err,
    output logic [31:0] PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [2:0] S_FLEN  = 3'd0;
    localparam logic [2:0] S_INCH  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_POLL  = 3'd3;
    localparam logic [2:0] S_CNT   = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;

    state_t      state;
    logic [2:0]  step;
    logic [15:0] poll_cnt;
    logic [5:0]  flen_q;
    logic [8:0]  inch_q;

    logic [2:0]  nxt_step;
    logic        to_resp;
    logic        timeout;
    logic        poll_inc;

    function automatic logic [31:0] step_addr(input logic [2:0] s);
        case (s)
            S_FLEN:  return BASE_ADDR + {24'd0, FLEN_OFS};
            S_INCH:  return BASE_ADDR + {24'd0, INCH_OFS};
            S_CNT:   return BASE_ADDR + {24'd0, CNT_OFS};
            default: return BASE_ADDR + {24'd0, CTRL_OFS};
        endcase
    endfunction

    function automatic logic step_wr(input logic [2:0] s);
        return (s != S_POLL) && (s != S_CNT);
    endfunction

    function automatic logic [31:0] step_wdata(input logic [2:0] s,
                                               input logic [5:0] fl,
                                               input logic [8:0] ic);
        case (s)
            S_FLEN:  return {26'd0, fl};
            S_INCH:  return {23'd0, ic};
            S_START: return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    // Where the sequence goes when the current transfer completes.
    always_comb begin
        nxt_step = S_STOP;
        to_resp  = 1'b0;
        timeout  = 1'b0;
        poll_inc = 1'b0;
        if (step == S_STOP) begin
            to_resp = 1'b1;
        end else if (PSLVERR) begin
            nxt_step = S_STOP;
        end else if (step == S_POLL) begin
            if (PRDATA[0]) begin
                nxt_step = S_CNT;
            end else if ({1'b0, poll_cnt} + 17'd1 >= {1'b0, POLL_MAX}) begin
                // done never came: still clear start before reporting
                timeout = 1'b1;
            end else begin
                nxt_step = S_POLL;
                poll_inc = 1'b1;
            end
        end else begin
            nxt_step = step + 3'd1;
        end
    end

    // Job FSM with registered APB and handshake outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            step       <= S_FLEN;
            poll_cnt   <= '0;
            flen_q     <= '0;
            inch_q     <= '0;
            rsp_err    <= 1'b0;
            rsp_cycles <= '0;
            rsp_valid  <= 1'b0;
            cmd_ready  <= 1'b1;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        flen_q     <= cmd_flen;
                        inch_q     <= cmd_inch;
                        step       <= S_FLEN;
                        poll_cnt   <= '0;
                        rsp_err    <= 1'b0;
                        rsp_cycles <= '0;
                        cmd_ready  <= 1'b0;
                        state      <= SETUP;
                        PSEL       <= 1'b1;
                        PENABLE    <= 1'b0;
                        PADDR      <= step_addr(S_FLEN);
                        PWRITE     <= step_wr(S_FLEN);
                        PWDATA     <= step_wdata(S_FLEN, cmd_flen, cmd_inch);
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        if (PSLVERR || timeout)
                            rsp_err <= 1'b1;
                        if (step == S_CNT && !PSLVERR)
                            rsp_cycles <= PRDATA;
                        if (poll_inc)
                            poll_cnt <= poll_cnt + 16'd1;
                        if (to_resp) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            PSEL      <= 1'b0;
                            PENABLE   <= 1'b0;
                            PWRITE    <= 1'b0;
                            PADDR     <= '0;
                            PWDATA    <= '0;
                        end else begin
                            state   <= SETUP;
                            step    <= nxt_step;
                            PENABLE <= 1'b0;
                            PADDR   <= step_addr(nxt_step);
                            PWRITE  <= step_wr(nxt_step);
                            PWDATA  <= step_wdata(nxt_step, flen_q, inch_q);
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pool_apb_master.sv
// Bench for pool_apb_master: an APB slave model with configurable wait
// states, done latency, counter value and error injection; each job's bus
// traffic and response are compared with a transaction list built from the
// job parameters.
module tb_pool_apb_master;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RESET, cmd_valid, rsp_ready, use4;
    logic [5:0]  cmd_flen;
    logic [8:0]  cmd_inch;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;

    logic        cmd_ready_a, rsp_valid_a, rsp_err_a, psel_a, pen_a, pwr_a;
    logic [31:0] rsp_cyc_a, paddr_a, pwdata_a;
    logic        cmd_ready_b, rsp_valid_b, rsp_err_b, psel_b, pen_b, pwr_b;
    logic [31:0] rsp_cyc_b, paddr_b, pwdata_b;

    // instance a: default parameters; instance b: relocated base, short poll limit
    pool_apb_master dut_a (
        .CLK(CLK), .RESET(RESET), .cmd_valid(cmd_valid & ~use4), .cmd_ready(cmd_ready_a),
        .cmd_flen(cmd_flen), .cmd_inch(cmd_inch), .rsp_valid(rsp_valid_a),
        .rsp_ready(rsp_ready), .rsp_cycles(rsp_cyc_a), .rsp_err(rsp_err_a),
        .PADDR(paddr_a), .PSEL(psel_a), .PENABLE(pen_a), .PWRITE(pwr_a), .PWDATA(pwdata_a),
        .PRDATA(PRDATA), .PREADY(PREADY & ~use4), .PSLVERR(PSLVERR));

    pool_apb_master #(.BASE_ADDR(32'h4000_0000), .POLL_MAX(16'd4)) dut_b (
        .CLK(CLK), .RESET(RESET), .cmd_valid(cmd_valid & use4), .cmd_ready(cmd_ready_b),
        .cmd_flen(cmd_flen), .cmd_inch(cmd_inch), .rsp_valid(rsp_valid_b),
        .rsp_ready(rsp_ready), .rsp_cycles(rsp_cyc_b), .rsp_err(rsp_err_b),
        .PADDR(paddr_b), .PSEL(psel_b), .PENABLE(pen_b), .PWRITE(pwr_b), .PWDATA(pwdata_b),
        .PRDATA(PRDATA), .PREADY(PREADY & use4), .PSLVERR(PSLVERR));

    logic        cmd_ready, rsp_valid, rsp_err, psel, pen, pwr;
    logic [31:0] rsp_cycles, paddr, pwdata, base_sel;
    assign cmd_ready  = use4 ? cmd_ready_b : cmd_ready_a;
    assign rsp_valid  = use4 ? rsp_valid_b : rsp_valid_a;
    assign rsp_err    = use4 ? rsp_err_b   : rsp_err_a;
    assign rsp_cycles = use4 ? rsp_cyc_b   : rsp_cyc_a;
    assign psel       = use4 ? psel_b      : psel_a;
    assign pen        = use4 ? pen_b       : pen_a;
    assign pwr        = use4 ? pwr_b       : pwr_a;
    assign paddr      = use4 ? paddr_b     : paddr_a;
    assign pwdata     = use4 ? pwdata_b    : pwdata_a;
    assign base_sel   = use4 ? 32'h4000_0000 : 32'h0;

    // slave configuration, driven by the stimulus process
    int          wait_n, done_after, slverr_at, job_xbase, job_pbase;
    logic [31:0] cnt_val, junk;

    // monitor state, written only by the monitor
    int          n_x = 0, n_polls = 0, proto_bad = 0, wcnt = 0;
    logic        prev_open = 1'b0;
    logic [64:0] prev_bus = '0;
    logic [64:0] xlog [0:4095];

    assign PREADY  = psel && pen && (wcnt >= wait_n);
    assign PSLVERR = psel && pen && ((n_x - job_xbase) == slverr_at);
    assign PRDATA  = (paddr == base_sel + 32'hC) ? cnt_val :
                     (paddr == base_sel) ? {junk[31:1], ((n_polls - job_pbase) >= done_after)} :
                     junk;

    // Bus monitor: logs completed transfers and counts protocol violations.
    always @(posedge CLK) begin
        if (RESET) begin
            wcnt      <= 0;
            prev_open <= 1'b0;
        end else begin
            wcnt <= (psel && pen && !PREADY) ? wcnt + 1 : 0;
            if (pen && !psel) proto_bad <= proto_bad + 1;
            if (!psel && (paddr != 32'd0 || pwdata != 32'd0 || pwr)) proto_bad <= proto_bad + 1;
            if (psel && pen && (!prev_open || prev_bus != {pwr, paddr, pwdata}))
                proto_bad <= proto_bad + 1;
            if (psel && !pen && prev_open) proto_bad <= proto_bad + 1;
            prev_open <= psel && !(pen && PREADY);
            prev_bus  <= {pwr, paddr, pwdata};
            if (psel && pen && PREADY) begin
                xlog[n_x[11:0]] <= {pwr, paddr, pwdata};
                n_x <= n_x + 1;
                if (!pwr && paddr == base_sel) n_polls <= n_polls + 1;
            end
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " cmd_ready"}, 65'(cmd_ready), 65'(1));
        chk({tag, " rsp_valid"}, 65'(rsp_valid), 65'(0));
        chk({tag, " bus"}, {psel, pen, pwr, paddr, pwdata}, 65'(0));
    endtask

    // One complete job: program slave, issue command, check traffic and response.
    task automatic run_job(input logic b4, input int fl, input int ic, input int da,
                           input int se, input int wn, input logic [31:0] cv,
                           input int hold, output int ncyc);
        logic [64:0] exq[$];
        logic [31:0] bs;
        int pmax, pb, n, cidx, idx;
        logic tmo, eerr;
        logic [31:0] ecyc;

        @(negedge CLK);
        use4 = b4; wait_n = wn; done_after = da; slverr_at = se; cnt_val = cv;
        junk = $urandom; job_xbase = n_x; job_pbase = n_polls; pb = proto_bad;
        cmd_flen = 6'(fl); cmd_inch = 9'(ic); cmd_valid = 1'b1;
        @(negedge CLK);
        chk("busy cmd_ready", 65'(cmd_ready), 65'(0));
        // commands offered while busy must be ignored and fields not re-latched
        cmd_flen = 6'($urandom); cmd_inch = 9'($urandom);
        n = 0;
        while (!rsp_valid && n < 3000) begin
            if (n == 3) cmd_valid = 1'b0;
            rsp_ready = (n < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge CLK);
            n++;
        end
        rsp_ready = 1'b0; cmd_valid = 1'b0;
        chk("rsp_valid seen", 65'(rsp_valid), 65'(1));

        // expected transaction list from the job parameters
        bs = b4 ? 32'h4000_0000 : 32'h0;
        pmax = b4 ? 4 : 65535;
        exq.push_back({1'b1, bs + 32'h4, 32'(fl)});
        exq.push_back({1'b1, bs + 32'h8, 32'(ic)});
        exq.push_back({1'b1, bs, 32'd1});
        tmo = (da >= pmax);
        if (!tmo) begin
            for (int i = 0; i <= da; i++) exq.push_back({1'b0, bs, 32'd0});
            exq.push_back({1'b0, bs + 32'hC, 32'd0});
        end else begin
            for (int i = 0; i < pmax; i++) exq.push_back({1'b0, bs, 32'd0});
        end
        exq.push_back({1'b1, bs, 32'd0});
        cidx = da + 4;
        eerr = tmo;
        ecyc = tmo ? 32'd0 : cv;
        if (se >= 0 && se < exq.size()) begin
            eerr = 1'b1;
            if (se <= cidx) ecyc = 32'd0;
            if (se < exq.size() - 1) begin
                while (exq.size() > se + 1) void'(exq.pop_back());
                exq.push_back({1'b1, bs, 32'd0});
            end
        end

        chk("xfer count", 65'(n_x - job_xbase), 65'(exq.size()));
        for (int i = 0; i < exq.size() && i < n_x - job_xbase; i++) begin
            idx = job_xbase + i;
            chk($sformatf("xfer%0d", i), xlog[idx[11:0]], exq[i]);
        end
        chk("rsp_cycles", 65'(rsp_cycles), 65'(ecyc));
        chk("rsp_err", 65'(rsp_err), 65'(eerr));
        for (int h = 0; h < hold; h++) begin
            @(negedge CLK);
            chk("hold rsp_valid", 65'(rsp_valid), 65'(1));
            chk("hold rsp_cycles", 65'(rsp_cycles), 65'(ecyc));
            chk("hold rsp_err", 65'(rsp_err), 65'(eerr));
        end
        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
        check_idle("post-rsp");
        chk("protocol", 65'(proto_bad), 65'(pb));
        ncyc = n;
    endtask

    initial begin
        int n, k, pb;
        RESET = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; use4 = 1'b0;
        cmd_flen = '0; cmd_inch = '0;
        wait_n = 0; done_after = 0; slverr_at = -1; cnt_val = '0; junk = '0;
        job_xbase = 0; job_pbase = 0;
        repeat (3) @(negedge CLK);
        check_idle("reset a");
        chk("reset rsp_err", 65'(rsp_err), 65'(0));
        chk("reset rsp_cycles", 65'(rsp_cycles), 65'(0));
        use4 = 1'b1;
        #1;
        check_idle("reset b");
        use4 = 1'b0;
        RESET = 1'b0;

        // nominal: six back-to-back transfers, 12 cycles to the response
        run_job(1'b0, 13, 64, 0, -1, 0, 32'd1234, 2, n);
        chk("nominal latency", 65'(n), 65'(12));
        // three wait states on each access
        run_job(1'b0, 13, 64, 0, -1, 3, 32'd1234, 0, n);
        chk("wait latency", 65'(n), 65'(30));
        // done after five not-done reads
        run_job(1'b0, 33, 300, 5, -1, 0, $urandom, 1, n);
        // poll timeout on the short-limit instance
        run_job(1'b1, 7, 300, 1000000, -1, 1, $urandom, 0, n);
        // slave error on the channel-count write
        run_job(1'b0, 21, 5, 0, 1, 0, $urandom, 1, n);

        // reset in the middle of the start-write access
        @(negedge CLK);
        use4 = 1'b0; wait_n = 4; done_after = 0; slverr_at = -1;
        job_xbase = n_x; job_pbase = n_polls; pb = proto_bad;
        cmd_flen = 6'd9; cmd_inch = 9'd17; cmd_valid = 1'b1;
        @(negedge CLK);
        cmd_valid = 1'b0;
        k = 0;
        while (!((n_x - job_xbase) == 2 && psel && pen) && k < 200) begin
            @(negedge CLK);
            k++;
        end
        chk("reached step2 access", 65'(k < 200), 65'(1));
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check_idle("mid-reset");
        chk("mid-reset rsp_err", 65'(rsp_err), 65'(0));
        k = n_x;
        repeat (4) @(negedge CLK);
        chk("no resume", 65'(n_x), 65'(k));
        check_idle("after reset idle");
        chk("reset protocol", 65'(proto_bad), 65'(pb));

        // randomized jobs across both instances
        for (int j = 0; j < 24; j++) begin
            logic b4;
            int se;
            b4 = 1'($urandom_range(0, 1));
            se = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_job(b4, int'($urandom_range(0, 63)), int'($urandom_range(0, 511)),
                    int'($urandom_range(0, 6)), se, int'($urandom_range(0, 2)),
                    $urandom, int'($urandom_range(0, 2)), n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
